snake_input_decoder: RTL and testbench

//  Receive end of the SGA button interface: conditions the raw 4-bit button bus into a move-direction command.

---
 rtl/snake_input_decoder_if.sv | 29 ++
 rtl/snake_input_decoder.sv | 178 +++++++++++++++++
 tb/tb_snake_input_decoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_input_decoder_if.sv
// Button-to-direction bus between the board-side decoder and the game controller.
// Carries game control inputs and the registered direction, pending and debug outputs.
// No flow control: every output is a level or a single-cycle pulse.
interface snake_input_decoder_if;
   logic       i_clear;
   logic       i_enable;
   logic       i_step;
   logic [3:0] i_buttons;
   logic [1:0] o_direction;
   logic       o_pending_valid;
   logic [1:0] o_pending_dir;
   logic       o_accepted;
   logic       o_rejected;
   logic [1:0] o_db_state;

   // Game controller side: drives control and buttons, reads direction.
   modport master (
      output i_clear, i_enable, i_step, i_buttons,
      input  o_direction, o_pending_valid, o_pending_dir,
      input  o_accepted, o_rejected, o_db_state
   );

   // Decoder side.
   modport slave (
      input  i_clear, i_enable, i_step, i_buttons,
      output o_direction, o_pending_valid, o_pending_dir,
      output o_accepted, o_rejected, o_db_state
   );
endinterface

// File: rtl/snake_input_decoder.sv
// Synchronises, debounces and filters raw buttons into a pending/committed snake direction.
// Latency: button level change to accepted/rejected pulse is DEBOUNCE_CYCLES+3 edges.
// No backpressure: pulses are single-cycle, the pending slot is simply overwritten.
module snake_input_decoder #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [1:0] INIT_DIR        = 2'b00
) (
   input  logic                   i_clock,
   input  logic                   i_restart_n,
   snake_input_decoder_if.slave   bus
);

   localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   logic [3:0]    r_sync1, r_sync2;
   logic [3:0]    r_cand, r_stable, r_stable_d;
   logic [CW-1:0] r_cnt;

   state_t        r_state;
   logic [1:0]    r_direction;
   logic          r_pend_vld;
   logic [1:0]    r_pend_dir;
   logic          r_accepted;
   logic          r_rejected;

   state_t        w_state_nxt;
   logic [1:0]    w_direction_nxt;
   logic          w_pend_vld_nxt;
   logic [1:0]    w_pend_dir_nxt;
   logic          w_accepted_nxt;
   logic          w_rejected_nxt;

   logic [3:0]    w_rise;
   logic          w_press_vld;
   logic [1:0]    w_press_dir;
   logic [1:0]    w_ref_dir;
   logic          w_is_rev;
   logic          w_is_same;
   logic          w_step_commit;

   // Two-flop synchroniser for the asynchronous button bus.
   always_ff @(posedge i_clock or negedge i_restart_n) begin
      if (!i_restart_n) begin
         r_sync1 <= 4'b0;
         r_sync2 <= 4'b0;
      end else begin
         r_sync1 <= bus.i_buttons;
         r_sync2 <= r_sync1;
      end
   end

   // Vector-wide debouncer; stable loads on the same edge the count saturates,
   // so a held change reaches stable exactly DEBOUNCE_CYCLES+2 edges after it appears.
   always_ff @(posedge i_clock or negedge i_restart_n) begin
      if (!i_restart_n) begin
         r_cand     <= 4'b0;
         r_cnt      <= '0;
         r_stable   <= 4'b0;
         r_stable_d <= 4'b0;
      end else begin
         r_stable_d <= r_stable;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt < CNT_LAST) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CNT_LOAD) begin
               r_stable <= r_cand;
            end
         end else begin
            r_stable <= r_cand;
         end
      end
   end

   // A press counts only when a single button rose and no other button is held.
   assign w_rise      = r_stable & ~r_stable_d;
   assign w_press_vld = $onehot(w_rise) && $onehot(r_stable);

   // Encode the rising button index as a direction code.
   always_comb begin
      w_press_dir = 2'b11;
      case (w_rise)
         4'b0001: w_press_dir = 2'b00;
         4'b0010: w_press_dir = 2'b01;
         4'b0100: w_press_dir = 2'b10;
         default: w_press_dir = 2'b11;
      endcase
   end

   // A step in the same cycle commits first, so the press is judged against the new heading.
   assign w_step_commit = bus.i_step && r_pend_vld;
   assign w_ref_dir     = w_step_commit ? r_pend_dir : r_direction;
   assign w_is_rev      = (w_press_dir == (w_ref_dir ^ 2'b01));
   assign w_is_same     = (w_press_dir == w_ref_dir);

   // State and registered outputs.
   always_ff @(posedge i_clock or negedge i_restart_n) begin
      if (!i_restart_n) begin
         r_state     <= ST_IDLE;
         r_direction <= INIT_DIR;
         r_pend_vld  <= 1'b0;
         r_pend_dir  <= 2'b00;
         r_accepted  <= 1'b0;
         r_rejected  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_direction <= w_direction_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_pend_dir  <= w_pend_dir_nxt;
         r_accepted  <= w_accepted_nxt;
         r_rejected  <= w_rejected_nxt;
      end
   end

   // Next-state: clear and pause dominate, otherwise track whether a direction is pending.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.i_clear || !bus.i_enable) begin
         w_state_nxt = ST_IDLE;
      end else if (r_state == ST_IDLE) begin
         w_state_nxt = ST_ARMED;
      end else if (w_press_vld && !w_is_rev) begin
         w_state_nxt = w_is_same ? ST_ARMED : ST_PENDING;
      end else if (bus.i_step && (r_state == ST_PENDING)) begin
         w_state_nxt = ST_ARMED;
      end
   end

   // Output/datapath next values: commit on step, then evaluate any press.
   always_comb begin
      w_direction_nxt = r_direction;
      w_pend_vld_nxt  = r_pend_vld;
      w_pend_dir_nxt  = r_pend_dir;
      w_accepted_nxt  = 1'b0;
      w_rejected_nxt  = 1'b0;
      if (bus.i_clear) begin
         w_direction_nxt = INIT_DIR;
         w_pend_vld_nxt  = 1'b0;
         w_pend_dir_nxt  = 2'b00;
      end else if (!bus.i_enable) begin
         w_pend_vld_nxt  = 1'b0;
         w_pend_dir_nxt  = 2'b00;
      end else if (r_state != ST_IDLE) begin
         if (w_step_commit) begin
            w_direction_nxt = r_pend_dir;
            w_pend_vld_nxt  = 1'b0;
         end
         if (w_press_vld) begin
            if (w_is_rev) begin
               w_rejected_nxt = 1'b1;
            end else if (w_is_same) begin
               w_pend_vld_nxt = 1'b0;
            end else begin
               w_pend_dir_nxt = w_press_dir;
               w_pend_vld_nxt = 1'b1;
               w_accepted_nxt = 1'b1;
            end
         end
      end
   end

   assign bus.o_direction     = r_direction;
   assign bus.o_pending_valid = r_pend_vld;
   assign bus.o_pending_dir   = r_pend_dir;
   assign bus.o_accepted      = r_accepted;
   assign bus.o_rejected      = r_rejected;
   assign bus.o_db_state      = r_state;

endmodule

// File: tb/tb_snake_input_decoder.sv
// Bench for snake_input_decoder: directed button sequences with a pulse scoreboard.
// Expected accepted/rejected events are queued by the stimulus and popped by a monitor.
// Direct checks cover reset, latency, commit on step, pause and clear.
module tb_snake_input_decoder;

   typedef struct packed {
      logic       acc;
      logic [1:0] dir;
   } ev_t;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   ev_t  exp_q[$];
   ev_t  mon_e;

   snake_input_decoder_if bus ();

   snake_input_decoder #(
      .DEBOUNCE_CYCLES (4),
      .INIT_DIR        (2'b00)
   ) dut (
      .i_clock     (clk),
      .i_restart_n (rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic acc, input logic [1:0] d);
      ev_t e;
      e.acc = acc;
      e.dir = d;
      exp_q.push_back(e);
   endtask

   task automatic press(input logic [3:0] b);
      bus.i_buttons = b;
      cyc(9);
      bus.i_buttons = 4'b0000;
      cyc(8);
   endtask

   task automatic step_pulse();
      bus.i_step = 1'b1;
      cyc(1);
      bus.i_step = 1'b0;
   endtask

   // Scoreboard monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (bus.o_accepted || bus.o_rejected)) begin
         check("pulse_exclusive", {7'b0, bus.o_accepted & bus.o_rejected}, 8'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: acc=%0b rej=%0b pdir=%0b, none required at %0t",
                     bus.o_accepted, bus.o_rejected, bus.o_pending_dir, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind_acc", {7'b0, bus.o_accepted}, {7'b0, mon_e.acc});
            if (mon_e.acc) check("pulse_pending_dir", {6'b0, bus.o_pending_dir}, {6'b0, mon_e.dir});
         end
      end
   end

   // Watchdog so a broken design cannot stall the run.
   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, got timeout required completion");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.i_clear   = 1'b0;
      bus.i_enable  = 1'b0;
      bus.i_step    = 1'b0;
      bus.i_buttons = 4'b0000;
      #5;
      check("rst_direction", {6'b0, bus.o_direction}, 8'h00);
      check("rst_pend_vld",  {7'b0, bus.o_pending_valid}, 8'h00);
      check("rst_pend_dir",  {6'b0, bus.o_pending_dir}, 8'h00);
      check("rst_state",     {6'b0, bus.o_db_state}, 8'h00);
      check("rst_pulses",    {6'b0, bus.o_accepted, bus.o_rejected}, 8'h00);
      cyc(2);
      rst_n        = 1'b1;
      bus.i_enable = 1'b1;
      cyc(1);
      check("armed_after_enable", {6'b0, bus.o_db_state}, 8'h01);

      // Press down: accepted exactly on the 7th edge after the change.
      push(1'b1, 2'b11);
      bus.i_buttons = 4'b1000;
      cyc(6);
      check("acc_before_edge7", {7'b0, bus.o_accepted}, 8'h00);
      cyc(1);
      check("acc_edge7",        {7'b0, bus.o_accepted}, 8'h01);
      check("t2_pend_vld",      {7'b0, bus.o_pending_valid}, 8'h01);
      check("t2_pend_dir",      {6'b0, bus.o_pending_dir}, 8'h03);
      check("t2_state_pending", {6'b0, bus.o_db_state}, 8'h02);
      cyc(1);
      check("acc_one_cycle",    {7'b0, bus.o_accepted}, 8'h00);
      cyc(2);
      bus.i_buttons = 4'b0000;
      cyc(8);
      step_pulse();
      check("t2_dir_after_step", {6'b0, bus.o_direction}, 8'h03);
      check("t2_pend_cleared",   {7'b0, bus.o_pending_valid}, 8'h00);
      check("t2_state_armed",    {6'b0, bus.o_db_state}, 8'h01);

      // 3-cycle glitch never registers.
      bus.i_buttons = 4'b0100;
      cyc(3);
      bus.i_buttons = 4'b0000;
      cyc(10);
      check("glitch_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      check("glitch_dir",      {6'b0, bus.o_direction}, 8'h03);

      // Clear back to right.
      bus.i_clear = 1'b1;
      cyc(1);
      bus.i_clear = 1'b0;
      check("clear_dir",   {6'b0, bus.o_direction}, 8'h00);
      check("clear_state", {6'b0, bus.o_db_state}, 8'h00);
      cyc(1);
      check("rearm_state", {6'b0, bus.o_db_state}, 8'h01);

      // Reversal of right is refused.
      push(1'b0, 2'b00);
      press(4'b0010);
      check("rev_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      check("rev_dir",      {6'b0, bus.o_direction}, 8'h00);

      push(1'b1, 2'b11); press(4'b1000); step_pulse();
      check("seq_dir_down", {6'b0, bus.o_direction}, 8'h03);
      push(1'b1, 2'b01); press(4'b0010); step_pulse();
      check("seq_dir_left", {6'b0, bus.o_direction}, 8'h01);
      push(1'b1, 2'b10); press(4'b0100); step_pulse();
      check("seq_dir_up",   {6'b0, bus.o_direction}, 8'h02);
      push(1'b1, 2'b00); press(4'b0001); step_pulse();
      check("seq_dir_right", {6'b0, bus.o_direction}, 8'h00);

      // Two buttons together are ignored; a second button added while holding is ignored.
      press(4'b1100);
      check("multi_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      push(1'b1, 2'b11);
      bus.i_buttons = 4'b1000;
      cyc(9);
      bus.i_buttons = 4'b1100;
      cyc(9);
      bus.i_buttons = 4'b0000;
      cyc(8);
      check("hold_pend_vld", {7'b0, bus.o_pending_valid}, 8'h01);
      check("hold_pend_dir", {6'b0, bus.o_pending_dir}, 8'h03);
      step_pulse();
      check("hold_dir_down", {6'b0, bus.o_direction}, 8'h03);

      // Set up direction right with up pending.
      push(1'b1, 2'b00); press(4'b0001); step_pulse();
      push(1'b1, 2'b10); press(4'b0100);
      check("setup_pend_dir", {6'b0, bus.o_pending_dir}, 8'h02);

      // Left on the step edge: judged against up (not a reversal), so accepted.
      push(1'b1, 2'b01);
      bus.i_buttons = 4'b0010;
      cyc(6);
      bus.i_step = 1'b1;
      cyc(1);
      bus.i_step = 1'b0;
      check("samecyc_dir",      {6'b0, bus.o_direction}, 8'h02);
      check("samecyc_pend_vld", {7'b0, bus.o_pending_valid}, 8'h01);
      check("samecyc_pend_dir", {6'b0, bus.o_pending_dir}, 8'h01);
      cyc(2);
      bus.i_buttons = 4'b0000;
      cyc(8);

      // Same direction as pending on the step edge: pending cleared, no pulse.
      bus.i_buttons = 4'b0010;
      cyc(6);
      bus.i_step = 1'b1;
      cyc(1);
      bus.i_step = 1'b0;
      check("same_dir",      {6'b0, bus.o_direction}, 8'h01);
      check("same_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      check("same_state",    {6'b0, bus.o_db_state}, 8'h01);
      cyc(2);
      bus.i_buttons = 4'b0000;
      cyc(8);

      // Pause drops the pending direction but keeps the committed one.
      push(1'b1, 2'b10); press(4'b0100);
      bus.i_enable = 1'b0;
      cyc(1);
      check("pause_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      check("pause_state",    {6'b0, bus.o_db_state}, 8'h00);
      check("pause_dir",      {6'b0, bus.o_direction}, 8'h01);
      bus.i_enable = 1'b1;
      cyc(1);

      // Asynchronous reset mid-cycle.
      #4 rst_n = 1'b0;
      #1;
      check("async_rst_dir",   {6'b0, bus.o_direction}, 8'h00);
      check("async_rst_state", {6'b0, bus.o_db_state}, 8'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1);
      check("post_rst_state", {6'b0, bus.o_db_state}, 8'h01);

      // Clear while a button is held: no new press afterwards.
      push(1'b1, 2'b11);
      bus.i_buttons = 4'b1000;
      cyc(9);
      check("held_pend_vld", {7'b0, bus.o_pending_valid}, 8'h01);
      bus.i_clear = 1'b1;
      cyc(1);
      bus.i_clear = 1'b0;
      check("held_clear_dir",      {6'b0, bus.o_direction}, 8'h00);
      check("held_clear_pend_vld", {7'b0, bus.o_pending_valid}, 8'h00);
      cyc(10);
      check("held_no_repress", {7'b0, bus.o_pending_valid}, 8'h00);
      bus.i_buttons = 4'b0000;
      cyc(8);

      check("leftover_events", exp_q.size()[7:0], 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
